// File: rtl/input_arbiter.sv
// ============================================================================
//  input_arbiter
//  Per-slot arbiter granting one of keyboard / mouse / sensor commands and
//  holding it for HOLD_CYCLES. Optional preemption: INPUT_ARB_PREEMPT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module input_arbiter #(
    parameter int HOLD_CYCLES = 833_333,
    parameter int HOLD_W      = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      kbd_valid,
    input  logic [3:0][5:0] kbd_cmd,
    input  logic [3:0]      mouse_valid,
    input  logic [3:0][5:0] mouse_cmd,
    input  logic [3:0]      sensor_valid,
    input  logic [3:0][5:0] sensor_cmd,
    output logic [3:0][5:0] input_signal,
    output logic [3:0][1:0] owner,
    output logic [7:0]      drop_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] RELOAD   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]        SRC_NONE = 2'd0;

    // Source codes double as bit positions in the 4-bit request vectors
    // (bit 0 is always 0), so a lower code means higher priority.
    function automatic logic [1:0] pick_src(input logic [3:0] m);
        if (m[1])      return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return SRC_NONE;
    endfunction

    function automatic logic [5:0] src_cmd(input logic [1:0] src,
                                           input logic [5:0] k,
                                           input logic [5:0] m,
                                           input logic [5:0] s);
        case (src)
            2'd1:    return k;
            2'd2:    return m;
            2'd3:    return s;
            default: return 6'd0;
        endcase
    endfunction

    logic [3:0] slot_drop;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        state_t            state, state_nxt;
        logic [1:0]        own_q, own_nxt;
        logic [5:0]        cmd_q, cmd_nxt;
        logic [HOLD_W-1:0] cnt_q, cnt_nxt;
        logic [3:0]        req, live;
        logic [1:0]        grant_src, win;
        logic [5:0]        own_cmd;
        logic              drop;

        assign req = {sensor_valid[i], mouse_valid[i], kbd_valid[i], 1'b0};
        assign live = req & {sensor_cmd[i] != 6'd0, mouse_cmd[i] != 6'd0,
                             kbd_cmd[i] != 6'd0, 1'b0};
        assign grant_src = pick_src(live);
        assign own_cmd   = src_cmd(own_q, kbd_cmd[i], mouse_cmd[i], sensor_cmd[i]);

`ifdef INPUT_ARB_PREEMPT_EN
        // Only sources strictly above the current owner may take over.
        assign win = pick_src(live & (((4'd1 << own_q) - 4'd1) & 4'b1110));
`else
        assign win = SRC_NONE;
`endif

        always_comb begin
            state_nxt = state;
            own_nxt   = own_q;
            cmd_nxt   = cmd_q;
            cnt_nxt   = cnt_q;
            drop      = 1'b0;
            case (state)
                IDLE: begin
                    if (|live) begin
                        own_nxt   = grant_src;
                        cmd_nxt   = src_cmd(grant_src, kbd_cmd[i], mouse_cmd[i],
                                            sensor_cmd[i]);
                        cnt_nxt   = RELOAD;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    drop = |(req & ~(4'd1 << own_q) & ~(4'd1 << win));
                    if (win != SRC_NONE) begin
                        own_nxt = win;
                        cmd_nxt = src_cmd(win, kbd_cmd[i], mouse_cmd[i], sensor_cmd[i]);
                        cnt_nxt = RELOAD;
                    end else if (req[own_q]) begin
                        if (own_cmd != 6'd0) begin
                            cmd_nxt = own_cmd;
                            cnt_nxt = RELOAD;
                        end else begin
                            own_nxt   = SRC_NONE;
                            cmd_nxt   = 6'd0;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end else if (cnt_q == '0) begin
                        own_nxt   = SRC_NONE;
                        cmd_nxt   = 6'd0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    own_nxt   = SRC_NONE;
                    cmd_nxt   = 6'd0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                own_q <= SRC_NONE;
                cmd_q <= 6'd0;
                cnt_q <= '0;
            end else begin
                state <= state_nxt;
                own_q <= own_nxt;
                cmd_q <= cmd_nxt;
                cnt_q <= cnt_nxt;
            end
        end

        assign input_signal[i] = cmd_q;
        assign owner[i]        = own_q;
        assign slot_drop[i]    = drop;
    end

    logic [2:0] drop_sum;
    logic [8:0] drop_acc;

    assign drop_sum = 3'(slot_drop[0]) + 3'(slot_drop[1])
                    + 3'(slot_drop[2]) + 3'(slot_drop[3]);
    assign drop_acc = {1'b0, drop_cnt} + {6'd0, drop_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= 8'd0;
        else        drop_cnt <= drop_acc[8] ? 8'hFF : drop_acc[7:0];
    end

endmodule

`default_nettype wire

// File: tb/tb_input_arbiter.sv
// ============================================================================
//  tb_input_arbiter
//  Randomised and directed bench for input_arbiter against a reference model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_arbiter;

    localparam int H = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      kbd_valid, mouse_valid, sensor_valid;
    logic [3:0][5:0] kbd_cmd, mouse_cmd, sensor_cmd;
    logic [3:0][5:0] input_signal;
    logic [3:0][1:0] owner;
    logic [7:0]      drop_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: owner, held command and remaining visible cycles per slot.
    int         m_own [4];
    logic [5:0] m_cmd [4];
    int         m_rem [4];
    int         m_drop;

    input_arbiter #(.HOLD_CYCLES(H), .HOLD_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kbd_valid    (kbd_valid),
        .kbd_cmd      (kbd_cmd),
        .mouse_valid  (mouse_valid),
        .mouse_cmd    (mouse_cmd),
        .sensor_valid (sensor_valid),
        .sensor_cmd   (sensor_cmd),
        .input_signal (input_signal),
        .owner        (owner),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0][5:0] exp_sig();
        logic [3:0][5:0] r;
        for (int s = 0; s < 4; s++) r[s] = m_cmd[s];
        return r;
    endfunction

    function automatic logic [3:0][1:0] exp_own();
        logic [3:0][1:0] r;
        for (int s = 0; s < 4; s++) r[s] = 2'(m_own[s]);
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_own[s] = 0;
            m_cmd[s] = 6'd0;
            m_rem[s] = 0;
        end
        m_drop = 0;
    endtask

    task automatic model_step();
        int drops;
        drops = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 4; s++) begin
            bit         v [4];
            logic [5:0] c [4];
            int         o, t;
            bit         dropped;
            v[0] = 0;               c[0] = 6'd0;
            v[1] = kbd_valid[s];    c[1] = kbd_cmd[s];
            v[2] = mouse_valid[s];  c[2] = mouse_cmd[s];
            v[3] = sensor_valid[s]; c[3] = sensor_cmd[s];
            o = m_own[s];
            if (o == 0) begin
                for (int src = 3; src >= 1; src--) begin
                    if (v[src] && c[src] != 6'd0) begin
                        m_own[s] = src; m_cmd[s] = c[src]; m_rem[s] = H;
                    end
                end
            end else begin
                t = 0;
`ifdef INPUT_ARB_PREEMPT_EN
                for (int src = o - 1; src >= 1; src--)
                    if (v[src] && c[src] != 6'd0) t = src;
`endif
                dropped = 0;
                for (int src = 1; src <= 3; src++)
                    if (src != o && src != t && v[src]) dropped = 1;
                if (dropped) drops++;
                if (t != 0) begin
                    m_own[s] = t; m_cmd[s] = c[t]; m_rem[s] = H;
                end else if (v[o] && c[o] != 6'd0) begin
                    m_cmd[s] = c[o]; m_rem[s] = H;
                end else if (v[o] || m_rem[s] == 1) begin
                    m_own[s] = 0; m_cmd[s] = 6'd0; m_rem[s] = 0;
                end else begin
                    m_rem[s]--;
                end
            end
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        kbd_valid = '0; mouse_valid = '0; sensor_valid = '0;
        for (int s = 0; s < 4; s++) begin
            kbd_cmd[s]    = 6'($urandom);
            mouse_cmd[s]  = 6'($urandom);
            sensor_cmd[s] = 6'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        kbd_valid = 4'hF; mouse_valid = 4'hF; sensor_valid = 4'hF;
        for (int s = 0; s < 4; s++) begin
            kbd_cmd[s] = 6'h15; mouse_cmd[s] = 6'h15; sensor_cmd[s] = 6'h15;
        end
        tick(); tick();
        n_vec++;
        if (input_signal !== 24'd0) begin
            n_fail++; $display("FAIL reset_sig got %h want 0", input_signal);
        end
        n_vec++;
        if (owner !== 8'd0) begin
            n_fail++; $display("FAIL reset_owner got %h want 0", owner);
        end
        n_vec++;
        if (drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt);
        end
        rst_n = 1'b1;
        tick();
        clear_inputs();
        n_vec++;
        if (input_signal !== {4{6'h15}}) begin
            n_fail++; $display("FAIL reset_grant_sig got %h want %h", input_signal, {4{6'h15}});
        end
        n_vec++;
        if (owner !== {4{2'd1}}) begin
            n_fail++; $display("FAIL reset_grant_owner got %h want %h", owner, {4{2'd1}});
        end
        repeat (H + 1) tick();
        n_vec++;
        if (input_signal !== exp_sig() || owner !== exp_own()) begin
            n_fail++; $display("FAIL reset_expire got %h/%h want %h/%h",
                               input_signal, owner, exp_sig(), exp_own());
        end
    endtask

    task automatic test_simultaneous();
        mouse_valid[2] = 1'b1;  mouse_cmd[2] = 6'h03;
        sensor_valid[2] = 1'b1; sensor_cmd[2] = 6'h0A;
        tick();
        clear_inputs();
        n_vec++;
        if (input_signal[2] !== 6'h03 || input_signal !== exp_sig()) begin
            n_fail++; $display("FAIL simul_sig got %h want %h", input_signal, exp_sig());
        end
        n_vec++;
        if (owner[2] !== 2'd2) begin
            n_fail++; $display("FAIL simul_owner got %0d want 2", owner[2]);
        end
        n_vec++;
        if (drop_cnt !== 8'(m_drop)) begin
            n_fail++; $display("FAIL simul_drop got %0d want %0d", drop_cnt, m_drop);
        end
        repeat (H + 1) tick();
    endtask

    task automatic test_hold_expiry();
        sensor_valid[0] = 1'b1; sensor_cmd[0] = 6'h21;
        tick();
        clear_inputs();
        for (int k = 0; k < H; k++) begin
            n_vec++;
            if (input_signal[0] !== 6'h21) begin
                n_fail++; $display("FAIL hold_cycle%0d got %h want 21", k, input_signal[0]);
            end
            tick();
        end
        n_vec++;
        if (input_signal[0] !== 6'h00 || owner[0] !== 2'd0) begin
            n_fail++; $display("FAIL expire got %h/%0d want 00/0", input_signal[0], owner[0]);
        end
        sensor_valid[0] = 1'b1; sensor_cmd[0] = 6'h21;
        tick();
        clear_inputs();
        for (int k = 0; k < 2 * H; k++) begin
            n_vec++;
            if (input_signal[0] !== 6'h21) begin
                n_fail++; $display("FAIL refresh_cycle%0d got %h want 21", k, input_signal[0]);
            end
            if (k == H - 1) begin
                sensor_valid[0] = 1'b1; sensor_cmd[0] = 6'h21;
            end
            tick();
            clear_inputs();
        end
        n_vec++;
        if (input_signal[0] !== 6'h00 || owner[0] !== 2'd0) begin
            n_fail++; $display("FAIL refresh_expire got %h/%0d want 00/0",
                               input_signal[0], owner[0]);
        end
    endtask

    task automatic test_strict_ownership();
        int base;
        mouse_valid[1] = 1'b1; mouse_cmd[1] = 6'h07;
        tick();
        clear_inputs();
        base = m_drop;
        for (int n = 0; n < 3; n++) begin
            kbd_valid[1] = 1'b1; kbd_cmd[1] = 6'h05;
            tick();
            clear_inputs();
            if (n == 0) begin
                n_vec++;
`ifdef INPUT_ARB_PREEMPT_EN
                if (owner[1] !== 2'd1 || input_signal[1] !== 6'h05) begin
                    n_fail++; $display("FAIL preempt got %0d/%h want 1/05", owner[1], input_signal[1]);
                end
`else
                if (owner[1] !== 2'd2 || input_signal[1] !== 6'h07) begin
                    n_fail++; $display("FAIL strict got %0d/%h want 2/07", owner[1], input_signal[1]);
                end
`endif
            end
            tick();
        end
        n_vec++;
`ifdef INPUT_ARB_PREEMPT_EN
        if (drop_cnt !== 8'(base)) begin
            n_fail++; $display("FAIL strict_drop got %0d want %0d", drop_cnt, base);
        end
`else
        if (drop_cnt !== 8'(base + 3)) begin
            n_fail++; $display("FAIL strict_drop got %0d want %0d", drop_cnt, base + 3);
        end
`endif
        // Owner releases with command 0.
`ifdef INPUT_ARB_PREEMPT_EN
        kbd_valid[1] = 1'b1; kbd_cmd[1] = 6'h00;
`else
        mouse_valid[1] = 1'b1; mouse_cmd[1] = 6'h00;
`endif
        tick();
        clear_inputs();
        n_vec++;
        if (input_signal[1] !== 6'h00 || owner[1] !== 2'd0) begin
            n_fail++; $display("FAIL release got %h/%0d want 00/0", input_signal[1], owner[1]);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            int denom;
            denom = ((n / 40) % 2 == 1) ? 16 : 4;
            for (int s = 0; s < 4; s++) begin
                kbd_valid[s]    = ($urandom_range(denom - 1) == 0);
                mouse_valid[s]  = ($urandom_range(denom - 1) == 0);
                sensor_valid[s] = ($urandom_range(denom - 1) == 0);
                kbd_cmd[s]    = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom);
                mouse_cmd[s]  = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom);
                sensor_cmd[s] = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom);
            end
            tick();
            n_vec++;
            if (input_signal !== exp_sig() || owner !== exp_own() || drop_cnt !== 8'(m_drop)) begin
                n_fail++;
                $display("FAIL random_cyc%0d got %h/%h/%0d want %h/%h/%0d", n,
                         input_signal, owner, drop_cnt, exp_sig(), exp_own(), m_drop);
            end
        end
        clear_inputs();
        repeat (H + 1) tick();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            kbd_valid[3] = 1'b1;    kbd_cmd[3] = 6'h11;
            sensor_valid[3] = 1'b1; sensor_cmd[3] = 6'h22;
            tick();
            n_vec++;
            if (drop_cnt !== 8'(m_drop)) begin
                n_fail++; $display("FAIL sat_cyc%0d got %0d want %0d", n, drop_cnt, m_drop);
            end
        end
        clear_inputs();
        tick();
        n_vec++;
        if (drop_cnt !== 8'd255) begin
            n_fail++; $display("FAIL saturate got %0d want 255", drop_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        kbd_valid[0] = 1'b1; kbd_cmd[0] = 6'h2A;
        tick();
        clear_inputs();
        tick(); tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (input_signal !== 24'd0 || owner !== 8'd0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_reset got %h/%h/%0d want 0/0/0",
                               input_signal, owner, drop_cnt);
        end
        #1 rst_n = 1'b1;
        tick();
        n_vec++;
        if (input_signal !== 24'd0 || owner !== 8'd0) begin
            n_fail++; $display("FAIL post_reset got %h/%h want 0/0", input_signal, owner);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simultaneous();
        test_hold_expiry();
        test_strict_ownership();
        test_random(400);
        test_saturation();
        test_reset_mid_hold();
        test_random(120);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
